// File: rtl/key_debounce_multi.sv
// -----------------------------------------------------------------------------
// key_debounce_multi
//
// Multi-channel push-button debouncer. Every channel is independent:
//   raw key -> 2-FF synchroniser (s1, s2) -> stability counter -> key_value
// A new level is accepted only after it has been seen on s2 for CNT_MAX
// consecutive cycles. Accepting a level produces a one-cycle press or release
// pulse. With LONG_PRESS_EN defined, each channel also has a hold counter that
// emits one long_press pulse LONG_MAX cycles after the press pulse.
//
// Build option:
//   LONG_PRESS_EN  - defined: hold counters are built and long_press is live.
//                    undefined: no hold counters, long_press is tied low.
//
// Parameters:
//   NUM_KEYS   number of channels (1..32)
//   CNT_MAX    stable cycles required to accept a new level (>= 2)
//   CNT_W      debounce counter width, 2**CNT_W > CNT_MAX-1
//   ACTIVE_LOW 1: pressed key reads 0, 0: pressed key reads 1
//   LONG_MAX   pressed cycles before long_press (LONG_PRESS_EN only)
//   LONG_W     hold counter width, 2**LONG_W > LONG_MAX-1
//
// Ports:
//   clk          system clock, rising edge
//   rstn         asynchronous active-low reset
//   key          raw asynchronous button inputs
//   key_value    debounced level per channel
//   press        one-cycle pulse when key_value enters the pressed level
//   release_evt  one-cycle pulse when key_value enters the idle level
//                ('release' is a reserved word in SystemVerilog)
//   long_press   one-cycle pulse after the hold time
// -----------------------------------------------------------------------------
module key_debounce_multi #(
  parameter int NUM_KEYS   = 4,
  parameter int CNT_MAX    = 1_000_000,
  parameter int CNT_W      = 20,
  parameter int ACTIVE_LOW = 1,
  parameter int LONG_MAX   = 50_000_000,
  parameter int LONG_W     = 26
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] key_value,
  output logic [NUM_KEYS-1:0] press,
  output logic [NUM_KEYS-1:0] release_evt,
  output logic [NUM_KEYS-1:0] long_press
);

  localparam logic                IDLE     = (ACTIVE_LOW != 0);
  localparam logic [NUM_KEYS-1:0] IDLE_VEC = {NUM_KEYS{IDLE}};
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(CNT_MAX - 1);

  // Reject configurations the counters cannot represent.
  generate
    if (NUM_KEYS < 1 || NUM_KEYS > 32 || CNT_MAX < 2 ||
        ((CNT_MAX - 1) >> CNT_W) != 0 || LONG_MAX < 1 ||
        ((LONG_MAX - 1) >> LONG_W) != 0) begin : g_bad_params
      $error("key_debounce_multi: illegal parameter combination");
    end
  endgenerate

  logic [NUM_KEYS-1:0] s1;
  logic [NUM_KEYS-1:0] s2;
  logic [CNT_W-1:0]    cnt [NUM_KEYS];
  logic [NUM_KEYS-1:0] accept;

  // A channel accepts s2 on the edge where it has already differed from
  // key_value for CNT_MAX-1 edges, i.e. this is the CNT_MAX-th one.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    accept = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      accept[i] = (s2[i] != key_value[i]) && (cnt[i] == CNT_LAST);
    end
  end

  // Synchronisers reset to the idle level so reset itself never looks like
  // a key change.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1 <= IDLE_VEC;
      s2 <= IDLE_VEC;
    end else begin
      s1 <= key;
      s2 <= s1;
    end
  end

  // NOTE: the counter array is reset explicitly; a reset mid-qualification
  // must discard the partial count rather than resume from it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      key_value   <= IDLE_VEC;
      press       <= '0;
      release_evt <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        press[i]       <= accept[i] && (s2[i] != IDLE);
        release_evt[i] <= accept[i] && (s2[i] == IDLE);
        // Any matching cycle restarts qualification; the counter stops at
        // CNT_MAX-1 because acceptance clears it on the next edge.
        if ((s2[i] == key_value[i]) || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
        if (accept[i]) begin
          key_value[i] <= s2[i];
        end
      end
    end
  end

`ifdef LONG_PRESS_EN
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_MAX - 1);

  logic [LONG_W-1:0]   hold  [NUM_KEYS];
  logic [NUM_KEYS-1:0] fired;

  // The hold counter sits at zero while the channel is idle, so it is zero on
  // the edge producing press. It counts while pressed and, on the edge after
  // it reaches LONG_MAX-1, fires once; 'fired' blocks any auto-repeat until
  // the key is released. The release edge itself clears it as well.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      long_press <= '0;
      fired      <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        hold[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        long_press[i] <= 1'b0;
        if ((key_value[i] == IDLE) || accept[i]) begin
          hold[i]  <= '0;
          fired[i] <= 1'b0;
        end else if (!fired[i]) begin
          if (hold[i] == LONG_LAST) begin
            long_press[i] <= 1'b1;
            fired[i]      <= 1'b1;
          end else begin
            hold[i] <= hold[i] + LONG_W'(1);
          end
        end
      end
    end
  end
`else
  assign long_press = '0;
`endif

endmodule

// File: tb/tb_key_debounce_multi.sv
// -----------------------------------------------------------------------------
// Testbench for key_debounce_multi (NUM_KEYS=4, CNT_MAX=8, ACTIVE_LOW=1,
// LONG_MAX=20). Stimulus pushes each expected event (edge number plus the
// press/release/long_press/key_value vectors) into a queue; a monitor pops
// and compares whenever any event output is high. Long-press expectations are
// only queued when LONG_PRESS_EN is defined; otherwise long_press must stay 0.
// -----------------------------------------------------------------------------
module tb_key_debounce_multi;

  localparam int NUM_KEYS = 4;
  localparam int CNT_MAX  = 8;
  localparam int LAT      = CNT_MAX + 2;  // raw change -> key_value edges

  logic                clk = 1'b0;
  logic                rstn;
  logic [NUM_KEYS-1:0] key;
  logic [NUM_KEYS-1:0] key_value;
  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] release_evt;
  logic [NUM_KEYS-1:0] long_press;

  key_debounce_multi #(
    .NUM_KEYS  (NUM_KEYS),
    .CNT_MAX   (CNT_MAX),
    .CNT_W     (4),
    .ACTIVE_LOW(1),
    .LONG_MAX  (20),
    .LONG_W    (5)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .key        (key),
    .key_value  (key_value),
    .press      (press),
    .release_evt(release_evt),
    .long_press (long_press)
  );

  always #5 clk = ~clk;

  // cyc equals N at the falling edge following rising edge N.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] p;
    logic [3:0] r;
    logic [3:0] l;
    logic [3:0] kv;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Queue an event expected dly edges after the current falling edge.
  task automatic expect_ev(input int dly, input logic [3:0] p,
                           input logic [3:0] r, input logic [3:0] l,
                           input logic [3:0] kv);
    ev_t e;
    e.cyc = cyc + dly;
    e.p   = p;
    e.r   = r;
    e.l   = l;
    e.kv  = kv;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: any event pulse must match the head of the queue.
  always @(negedge clk) begin
    ev_t e;
    if ((press | release_evt | long_press) !== 4'b0000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {20'h0, press, release_evt, long_press}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("event_cycle", cyc, e.cyc);
        check("event_vectors", {press, release_evt, long_press, key_value},
              {e.p, e.r, e.l, e.kv});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with all raw keys pressed.
    rstn = 1'b0;
    key  = 4'b0000;
    repeat (3) begin
      @(negedge clk);
      check("rst_key_value", key_value, 4'hF);
      check("rst_events", {press, release_evt, long_press}, 12'h0);
    end
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_key_value", key_value, 4'hF);
    check("post_rst_events", {press, release_evt, long_press}, 12'h0);
    key = 4'hF;
    wait_cyc(15);
    check("idle_key_value", key_value, 4'hF);

    // Clean press and release on channel 0.
    key = 4'b1110;
    expect_ev(LAT, 4'b0001, 4'b0000, 4'b0000, 4'b1110);
    wait_cyc(15);
    check("clean_press_kv", key_value, 4'b1110);
    key = 4'hF;
    expect_ev(LAT, 4'b0000, 4'b0001, 4'b0000, 4'hF);
    wait_cyc(15);
    check("clean_release_kv", key_value, 4'hF);

    // Bounce on channel 1: 3-cycle segments for 30 cycles, then hold low.
    for (int t = 0; t < 10; t++) begin
      key[1] = (t % 2 == 1);
      wait_cyc(3);
    end
    key[1] = 1'b0;
    expect_ev(LAT, 4'b0010, 4'b0000, 4'b0000, 4'b1101);
    wait_cyc(15);
    check("bounce_kv", key_value, 4'b1101);
    key[1] = 1'b1;
    expect_ev(LAT, 4'b0000, 4'b0010, 4'b0000, 4'hF);
    wait_cyc(15);

    // Longest rejected glitch on channel 2: 7 cycles low.
    key[2] = 1'b0;
    wait_cyc(7);
    key[2] = 1'b1;
    wait_cyc(15);
    check("glitch_kv", key_value, 4'hF);

    // Channel 3 pressed, then released on the same cycle channel 0 presses.
    key = 4'b0111;
    expect_ev(LAT, 4'b1000, 4'b0000, 4'b0000, 4'b0111);
    wait_cyc(12);
    key = 4'b1110;
    expect_ev(LAT, 4'b0001, 4'b1000, 4'b0000, 4'b1110);
`ifdef LONG_PRESS_EN
    // Long press on channel 0: 20 cycles after its press pulse, once only.
    expect_ev(LAT + 20, 4'b0000, 4'b0000, 4'b0001, 4'b1110);
`endif
    wait_cyc(60);
    check("long_hold_kv", key_value, 4'b1110);
    key = 4'hF;
    expect_ev(LAT, 4'b0000, 4'b0001, 4'b0000, 4'hF);
    wait_cyc(15);

    // Reset 10 cycles into a hold must discard it silently.
    key = 4'b1110;
    expect_ev(LAT, 4'b0001, 4'b0000, 4'b0000, 4'b1110);
    wait_cyc(LAT + 10);
    rstn = 1'b0;
    key  = 4'hF;
    @(negedge clk);
    check("mid_hold_rst_kv", key_value, 4'hF);
    rstn = 1'b1;
    wait_cyc(40);
    check("after_hold_rst_kv", key_value, 4'hF);

    check("all_events_seen", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_debounce_multi.md
# key_debounce_multi

Parametrised multi-channel key debouncer with per-channel press/release event pulses and an optional long-press event. It sits between raw board push-button pins and the control logic: one instance serves a whole key bank, replacing per-key single-channel debouncers. Each channel synchronises its raw input, requires a configurable number of stable cycles before it accepts a new level, and emits single-cycle edge events on the accepted level.

## Interface
Parameters:
- NUM_KEYS, 4: number of independent key channels (1 to 32).
- CNT_MAX, 1_000_000: consecutive stable cycles required to accept a new level (at least 2).
- CNT_W, 20: debounce counter width; must satisfy 2^CNT_W > CNT_MAX-1.
- ACTIVE_LOW, 1: 1 means a pressed key reads 0; 0 means a pressed key reads 1.
- LONG_MAX, 50_000_000: cycles of accepted-pressed state before a long-press event. Used only with LONG_PRESS_EN.
- LONG_W, 26: hold counter width; must satisfy 2^LONG_W > LONG_MAX-1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rstn  in  1  asynchronous, active-low reset.
- key  in  NUM_KEYS  raw, asynchronous button inputs.
- key_value  out  NUM_KEYS  debounced level per channel.
- press  out  NUM_KEYS  one-cycle pulse when key_value enters the pressed level.
- release  out  NUM_KEYS  one-cycle pulse when key_value enters the idle level.
- long_press  out  NUM_KEYS  one-cycle pulse after the hold time (see Configuration).

## Operation
- Idle level IDLE = ACTIVE_LOW ? 1 : 0. On reset, all registers are cleared:
  - key_value = all IDLE; both synchroniser stages = all IDLE.
  - press, release and long_press = 0; all counters = 0.
- Channels are fully independent. Each channel has:
  - a 2-FF synchroniser, s1 feeding s2;
  - a debounce counter cnt (CNT_W bits);
  - a registered key_value bit.
- Per channel, on each edge:
  - If s2 == key_value: cnt <= 0.
  - If s2 != key_value and cnt < CNT_MAX-1: cnt <= cnt+1.
  - If s2 != key_value and cnt == CNT_MAX-1: key_value <= s2 and cnt <= 0. On the same edge, press <= (s2 != IDLE) and release <= (s2 == IDLE).
  - press and release are 0 on every other cycle. They are never high together on one channel.
- Any single cycle where s2 matches key_value restarts the qualification, so a bounce shorter than CNT_MAX cycles never changes key_value.
- cnt never exceeds CNT_MAX-1 and does not wrap.
- Reset mid-qualification or mid-hold discards the count. No event fires as a result of the reset.

## Timing
- Latency from a raw key change (held stable) to the key_value update is 2 + CNT_MAX rising edges: 2 synchroniser edges plus CNT_MAX qualifying edges.
- press and release assert on the same edge as the key_value update and last exactly one cycle.
- Minimum spacing between successive events on one channel is CNT_MAX cycles.
- Events on different channels may occur in the same cycle; each is reported independently.
- All outputs are registered; there is no combinational path from key.

## Configuration
- Macro LONG_PRESS_EN.
- Defined: each channel adds a hold counter (LONG_W bits).
  - The hold counter clears on the edge that produces press, then increments each cycle while key_value is pressed.
  - When it reaches LONG_MAX-1, long_press pulses for one cycle and the counter holds. It fires once per press and does not auto-repeat.
  - release, or key_value returning to IDLE, clears the counter.
  - long_press therefore asserts LONG_MAX cycles after the press pulse.
- Not defined: no hold counters are built; long_press is tied to 0. The port list is identical in both builds.

## Test plan
All scenarios use NUM_KEYS=4, CNT_MAX=8, ACTIVE_LOW=1; LONG_PRESS_EN is defined with LONG_MAX=20.
- Reset: assert rstn=0 with key=4'b0000 → key_value=4'hF, press=release=long_press=0 throughout reset and one cycle after.
- Clean press: key[0] goes 1→0 and holds → key_value[0] falls on the 10th edge, with a single press[0] pulse on that edge. Releasing 1 gives key_value[0]=1 ten edges later with one release[0] pulse.
- Bounce: key[1] toggles every 3 cycles for 30 cycles, then holds 0 → exactly one press[1] pulse, 10 edges after the final toggle, and no release[1].
- Short glitch: key[2] held at 0 for 7 cycles, then back to 1 → key_value[2] stays 1 and no events fire.
- Simultaneous events: ch3 (previously debounced-pressed) is released and ch0 is pressed on the same cycle → release[3] and press[0] pulse on the same edge; channels 1 and 2 are unaffected.
- Long press and reset: hold key[0]=0 → long_press[0] pulses 20 cycles after press[0], once only. A repeat where rstn is pulsed 10 cycles after press gives no long_press and key_value=4'hF.
